watchdog_multi: RTL and testbench

- Parametrised multi-channel watchdog: successor to the single fixed-width free-running watchdog counter used in the core testbench.
- Each channel has a programmable timeout, warning margin, kick (service) input, sticky expiry flag with acknowledge, and a one-cycle expiry pulse.
- Used by testbenches to stop hung simulations, and by SoC integration to supervise core, memory and bus activity independently.

---
 rtl/watchdog_multi_pkg.sv | 13 +
 rtl/watchdog_channel.sv | 105 ++++++++++
 rtl/watchdog_multi.sv | 72 +++++++
 tb/tb_watchdog_multi.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/watchdog_multi_pkg.sv
// Shared types and limits for the multi-channel watchdog.
package watchdog_multi_pkg;

    typedef enum logic [1:0] {
        WD_IDLE,
        WD_RUN,
        WD_WARN,
        WD_EXPIRED
    } wd_state_e;

    localparam int MAX_CH = 16;

endpackage

// File: rtl/watchdog_channel.sv
// One watchdog channel: FSM, count and latched limit; counts on tick, flags
// warning/expiry as registered outputs.
module watchdog_channel
    import watchdog_multi_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic             kick,
    input  logic             ack,
    input  logic [WIDTH-1:0] timeout,
    input  logic [WIDTH-1:0] warn_margin,
    output logic [WIDTH-1:0] count,
    output logic             warning,
    output logic             expired,
    output logic             expire_pulse
);

    wd_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             warning_q, warning_d;
    logic             expired_q, expired_d;
    logic             pulse_q, pulse_d;
    logic [WIDTH:0]   nxt, remain;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        pulse_d = 1'b0;
        // One extra bit so count+1 never wraps against the limit.
        nxt     = {1'b0, count_q} + 1'b1;
        remain  = {1'b0, limit_q} - nxt;
        case (state_q)
            WD_IDLE: begin
                if (en) begin
                    limit_d = timeout;
                    count_d = '0;
                    state_d = WD_RUN;
                end
            end
            WD_RUN, WD_WARN: begin
                if (!en) begin
                    count_d = '0;
                    state_d = WD_IDLE;
                end else if (kick) begin
                    count_d = '0;
                    limit_d = timeout;
                    state_d = WD_RUN;
                end else if (tick) begin
                    if (nxt >= {1'b0, limit_q}) begin
                        count_d = limit_q;
                        state_d = WD_EXPIRED;
                        pulse_d = 1'b1;
                    end else begin
                        count_d = nxt[WIDTH-1:0];
                        state_d = (remain <= {1'b0, warn_margin}) ? WD_WARN : WD_RUN;
                    end
                end
            end
            WD_EXPIRED: begin
                if (ack) begin
                    count_d = '0;
                    if (en) begin
                        limit_d = timeout;
                        state_d = WD_RUN;
                    end else begin
                        state_d = WD_IDLE;
                    end
                end
            end
            default: state_d = WD_IDLE;
        endcase
        warning_d = (state_d == WD_WARN);
        expired_d = (state_d == WD_EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WD_IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            warning_q <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            warning_q <= warning_d;
            expired_q <= expired_d;
            pulse_q   <= pulse_d;
        end
    end

    assign count        = count_q;
    assign warning      = warning_q;
    assign expired      = expired_q;
    assign expire_pulse = pulse_q;

endmodule

// File: rtl/watchdog_multi.sv
// Multi-channel watchdog top: NUM_CH independent channels plus a shared tick.
// Define WATCHDOG_MULTI_PRESCALE_EN to build the tick prescaler.
module watchdog_multi
    import watchdog_multi_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       kick,
    input  logic [NUM_CH*WIDTH-1:0] timeout,
    input  logic [WIDTH-1:0]        warn_margin,
    input  logic [NUM_CH-1:0]       ack,
    input  logic [PRESCALE_W-1:0]   prescale_div,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       warning,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH-1:0]       expire_pulse,
    output logic                    any_expired
);

    logic tick;

`ifdef WATCHDOG_MULTI_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] div_q, div_d;

    // The divider is captured only at wrap so a new D starts on a clean period.
    always_comb begin
        tick    = (presc_q >= div_q);
        presc_d = tick ? '0 : presc_q + 1'b1;
        div_d   = tick ? prescale_div : div_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            div_q   <= '0;
        end else begin
            presc_q <= presc_d;
            div_q   <= div_d;
        end
    end
`else
    logic unused_prescale;
    assign tick            = 1'b1;
    assign unused_prescale = ^prescale_div;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        watchdog_channel #(.WIDTH(WIDTH)) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .en           (en[g]),
            .kick         (kick[g]),
            .ack          (ack[g]),
            .timeout      (timeout[g*WIDTH +: WIDTH]),
            .warn_margin  (warn_margin),
            .count        (count[g*WIDTH +: WIDTH]),
            .warning      (warning[g]),
            .expired      (expired[g]),
            .expire_pulse (expire_pulse[g])
        );
    end

    assign any_expired = |expired;

endmodule

// File: tb/tb_watchdog_multi.sv
// Scoreboard bench for watchdog_multi (NUM_CH=2, WIDTH=8): stimulus queues
// hand-computed per-cycle expectations, a negedge monitor pops and compares.
module tb_watchdog_multi;

    localparam int NCH = 2;
    localparam int W   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   en = '0, kick = '0, ack = '0;
    logic [NCH*W-1:0] timeout = '0;
    logic [W-1:0]     warn_margin = '0;
    logic [7:0]       prescale_div = '0;
    logic [NCH*W-1:0] count;
    logic [NCH-1:0]   warning, expired, expire_pulse;
    logic             any_expired;

    watchdog_multi #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .kick         (kick),
        .timeout      (timeout),
        .warn_margin  (warn_margin),
        .ack          (ack),
        .prescale_div (prescale_div),
        .count        (count),
        .warning      (warning),
        .expired      (expired),
        .expire_pulse (expire_pulse),
        .any_expired  (any_expired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        int       ch;
        logic [7:0] cnt;
        logic     w, e, p, a;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int c, input int ch, input int cnt,
                        input logic w, input logic e, input logic p, input logic a);
        exp_t x;
        x.cyc = c; x.ch = ch; x.cnt = cnt[7:0];
        x.w = w; x.e = e; x.p = p; x.a = a;
        q.push_back(x);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation due in the cycle just completed.
    always @(negedge clk) begin
        exp_t x;
        logic [11:0] act, req;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            x   = q.pop_front();
            act = {count[x.ch*W +: W], warning[x.ch], expired[x.ch], expire_pulse[x.ch], any_expired};
            req = {x.cnt, x.w, x.e, x.p, x.a};
            checks++;
            if (x.cyc != cyc || act !== req) begin
                errors++;
                $display("FAIL cyc%0d(due %0d) ch%0d: got cnt=%0d warn=%b exp=%b pulse=%b any=%b want cnt=%0d warn=%b exp=%b pulse=%b any=%b",
                         cyc, x.cyc, x.ch, act[11:4], act[3], act[2], act[1], act[0],
                         x.cnt, x.w, x.e, x.p, x.a);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        int c1;
        int cnt2[16] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 4, 5, 5};

        // Reset state
        push(2, 0, 0, 0, 0, 0, 0);
        push(2, 1, 0, 0, 0, 0, 0);
        wait_to(3);
        rst = 1'b0;

        // 1: free run to expiry, L=5 M=2
        timeout[7:0] = 8'd5; warn_margin = 8'd2; en[0] = 1'b1;
        b = cyc + 1;
        for (int k = 0; k < 8; k++)
            push(b + k, 0, (k < 5) ? k : 5, (k == 3 || k == 4), (k >= 5), (k == 5), (k >= 5));
        wait_to(b + 7);
        en[0] = 1'b0; ack[0] = 1'b1;
        push(b + 8, 0, 0, 0, 0, 0, 0);
        wait_to(b + 8);
        ack[0] = 1'b0;

        // 2: kicks at +3,+6,+9 hold off expiry; then expire 5 ticks later
        en[0] = 1'b1;
        b = cyc + 1;
        for (int k = 0; k < 16; k++)
            push(b + k, 0, cnt2[k], (k == 12 || k == 13), (k >= 14), (k == 14), (k >= 14));
        for (int kk = 3; kk <= 9; kk += 3) begin
            wait_to(b + kk - 1);
            kick[0] = 1'b1;
            wait_to(b + kk);
            kick[0] = 1'b0;
        end

        // 3: kick/en-drop ignored while expired; ack with en reloads L=10
        wait_to(b + 15);
        kick[0] = 1'b1; en[0] = 1'b0;
        push(b + 16, 0, 5, 0, 1, 0, 1);
        push(b + 17, 0, 5, 0, 1, 0, 1);
        wait_to(b + 17);
        kick[0] = 1'b0; en[0] = 1'b1; timeout[7:0] = 8'd10; ack[0] = 1'b1;
        for (int k = 0; k <= 10; k++)
            push(b + 18 + k, 0, k, (k == 8 || k == 9), (k == 10), (k == 10), (k == 10));
        wait_to(b + 18);
        ack[0] = 1'b0;
        wait_to(b + 28);
        en[0] = 1'b0; ack[0] = 1'b1;
        push(b + 29, 0, 0, 0, 0, 0, 0);
        wait_to(b + 29);
        ack[0] = 1'b0;

        // 4: simultaneous expiry, any_expired held until last ack
        timeout = {8'd4, 8'd4}; warn_margin = 8'd0; en = 2'b11;
        b = cyc + 1;
        for (int k = 0; k < 6; k++)
            for (int ch = 0; ch < 2; ch++)
                push(b + k, ch, (k < 4) ? k : 4, 0, (k >= 4), (k == 4), (k >= 4));
        wait_to(b + 5);
        ack[0] = 1'b1; en[0] = 1'b0;
        for (int k = 6; k <= 7; k++) begin
            push(b + k, 0, 0, 0, 0, 0, 1);
            push(b + k, 1, 4, 0, 1, 0, 1);
        end
        wait_to(b + 6);
        ack[0] = 1'b0;
        wait_to(b + 7);
        en[1] = 1'b0; ack[1] = 1'b1;
        push(b + 8, 0, 0, 0, 0, 0, 0);
        push(b + 8, 1, 0, 0, 0, 0, 0);
        wait_to(b + 8);
        ack[1] = 1'b0;

        // 5: reset while in WARN at count 7, re-arms with en still high
        timeout[7:0] = 8'd10; warn_margin = 8'd3; en[0] = 1'b1;
        b = cyc + 1;
        for (int k = 0; k < 8; k++)
            push(b + k, 0, k, (k >= 7), 0, 0, 0);
        wait_to(b + 7);
        rst = 1'b1;
        push(b + 8, 0, 0, 0, 0, 0, 0);
        wait_to(b + 8);
        rst = 1'b0;
        push(b + 9, 0, 0, 0, 0, 0, 0);
        push(b + 10, 0, 1, 0, 0, 0, 0);
        push(b + 11, 0, 2, 0, 0, 0, 0);
        wait_to(b + 11);
        en[0] = 1'b0;
        wait_to(b + 12);

        // 6: L=0 on ch0 expires on first tick; M>=L on ch1 warns at once
        timeout = {8'd3, 8'd0}; warn_margin = 8'd5; en = 2'b11;
        b = cyc + 1;
        push(b, 0, 0, 0, 0, 0, 0);
        push(b, 1, 0, 0, 0, 0, 0);
        push(b + 1, 0, 0, 0, 1, 1, 1);
        push(b + 1, 1, 1, 1, 0, 0, 1);
        push(b + 2, 0, 0, 0, 1, 0, 1);
        push(b + 2, 1, 2, 1, 0, 0, 1);
        push(b + 3, 0, 0, 0, 1, 0, 1);
        push(b + 3, 1, 3, 0, 1, 1, 1);
        wait_to(b + 3);
        en = 2'b00; ack = 2'b11;
        wait_to(b + 4);
        ack = 2'b00;
        wait_to(b + 5);

`ifdef WATCHDOG_MULTI_PRESCALE_EN
        // 7: D=3, L=2 -> one count step every 4 cycles
        prescale_div = 8'd3; timeout[7:0] = 8'd2; warn_margin = 8'd0; en[0] = 1'b1;
        c1 = -1;
        for (int n = 0; n < 20 && c1 < 0; n++) begin
            wait_to(cyc + 1);
            if (count[7:0] == 8'd1) c1 = cyc;
        end
        if (c1 < 0) begin
            checks++; errors++;
            $display("FAIL prescale_first_step: count never reached 1 (got %0d)", count[7:0]);
        end else begin
            push(c1 + 3, 0, 1, 0, 0, 0, 0);
            push(c1 + 4, 0, 2, 0, 1, 1, 1);
            wait_to(c1 + 5);
        end
`else
        c1 = 0;
`endif

        wait_to(cyc + 3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
